serial_pattern_tx: RTL and testbench
====================================

Name: serial_pattern_tx

Overview:
- Upstream feeder for the serial sequence detector.
- Accepts bytes over a valid/ready interface and buffers them in a small FIFO.
- Shifts each byte out MSB-first, one bit per clock, on ds. The detector consumes ds directly.
- Back-to-back bytes produce a continuous, gap-free bit stream, so 8-bit patterns are detectable across byte boundaries.

Parameters:
- DEPTH, 4, FIFO depth in bytes; power of 2, minimum 2.
- CNT_W, 3, width of fifo_cnt; equals log2(DEPTH)+1.

Ports:
- clk  input  1  system clock, rising edge.
- clrn  input  1  asynchronous active-low reset.
- din  input  8  byte to transmit.
- din_valid  input  1  din is valid this cycle.
- din_ready  output  1  FIFO can accept a byte; equals (fifo_cnt < DEPTH).
- en  input  1  shift enable; 0 freezes the shifter.
- ds  output  1  serial data out; driven from shift register bit 7.
- ds_valid  output  1  ds carries a real data bit this cycle.
- busy  output  1  shifter holds a byte (state SHIFT).
- fifo_cnt  output  CNT_W  FIFO occupancy.

Behaviour:
- Interface decision: one clock (clk); reset clrn is asynchronous and active-low.
- Reset (clrn=0, asynchronous): FIFO empty, fifo_cnt=0, din_ready=1, shift reg=0, ds=0, ds_valid=0, busy=0, bit counter=0, state IDLE. Reset mid-byte discards the partial byte and all buffered bytes.
- Push: a byte is written on a rising edge where din_valid && din_ready. No pass-through when full.
- Push and pop in the same edge: fifo_cnt unchanged.
- Pointers wrap modulo DEPTH.
- State IDLE:
  - ds=0, ds_valid=0.
  - If fifo_cnt>0 and en=1: pop the head into the shift reg, bitcnt=0, go to SHIFT.
- State SHIFT:
  - ds=sh[7]; ds_valid=en.
  - On each edge with en=1: if bitcnt<7, shift left by 1 and bitcnt+1.
  - If bitcnt==7 and FIFO non-empty: pop the next byte, bitcnt=0, stay in SHIFT (zero gap).
  - If bitcnt==7 and FIFO empty: go to IDLE.
  - en=0: shift reg, bitcnt and state hold; ds holds its value; ds_valid=0.
- Latency: a byte pushed at edge N into an empty, idle block is popped at edge N+1. Its MSB appears on ds after edge N+1. Its 8 bits occupy the 8 cycles following N+1.
- Push while FIFO empty and the shifter finishing bit 7 (same edge): the byte is not yet poppable. The shifter goes to IDLE and pops at the next edge, giving a one-cycle gap.
- A pop takes a FIFO slot. din_ready can rise in the same cycle the shifter loads.

Optional Feature:
- Macro: SERIAL_PRBS_FILL_EN.
- Defined: in IDLE, ds is driven by an 8-bit Fibonacci LFSR.
  - Polynomial x^8+x^6+x^5+x^4+1; seed 8'h01 at reset.
  - The LFSR advances on each IDLE cycle with en=1. Output is the LFSR MSB.
  - ds_valid stays 0 during fill.
- Undefined: IDLE ds=0; no LFSR logic synthesised.

Decomposition:
- Shared package, serial_pkg:
  - Constant DATA_W=8.
  - State typedef {IDLE, SHIFT}.
  - LFSR seed and tap constants.
- One sub-module, byte_fifo:
  - Synchronous FIFO with parameter DEPTH.
  - Ports: push, pop, wdata, rdata (head, combinational), count, full, empty.
  - Same clk/clrn.
- The top module holds the shifter FSM.

Test Plan:
- Reset, then push 8'hB5 once -> ds=1,0,1,1,0,1,0,1 with ds_valid=1 for the 8 cycles after the pop edge; then ds=0, busy=0.
- Push 8'hA5 then 8'h3C on consecutive cycles -> 16 contiguous valid bits 1010010100111100, no gap; fifo_cnt peaks at 1.
- Push 5 bytes back-to-back while the shifter is busy with byte 0 -> FIFO fills; din_ready=0 when fifo_cnt=4; the 5th byte is held until a pop; all 5 bytes are serialised in order.
- Drive en=0 for 3 cycles after bit 3 of 8'hF0 -> ds holds 0 and ds_valid=0 for those 3 cycles; the remaining bits 0,0,0,0 resume afterwards.
- Assert clrn=0 asynchronously mid-byte with 2 bytes queued -> immediately ds=0, fifo_cnt=0, busy=0; after release, no residual bits are output.
- With SERIAL_PRBS_FILL_EN defined, idle 10 cycles after reset -> ds follows the LFSR from seed 8'h01 and ds_valid=0 throughout; a pushed byte then overrides the fill.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared constants and types for the serial pattern transmitter.
// The LFSR constants are only consumed when SERIAL_PRBS_FILL_EN is defined.
package serial_pkg;

  localparam int DATA_W   = 8;
  localparam int BITCNT_W = 3;

  // Index of the last bit of a byte; reaching it ends the byte.
  localparam logic [BITCNT_W-1:0] BIT_LAST = 3'd7;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Fibonacci LFSR for idle fill, polynomial x^8+x^6+x^5+x^4+1.
  // The tap mask selects register bits 7,5,4,3 (exponent k maps to bit k-1).
  localparam logic [DATA_W-1:0] LFSR_SEED = 8'h01;
  localparam logic [DATA_W-1:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/serial_pattern_tx_byte_fifo.sv
// byte_fifo: small synchronous FIFO with a combinational head (rdata).
// Push is ignored when full and pop is ignored when empty, so a push into an
// empty FIFO becomes poppable only on the following edge.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // Next-state for storage, pointers (wrap naturally, DEPTH is a power of 2) and occupancy.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // FIFO registers; reset empties the FIFO and clears stale contents.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: buffers bytes in byte_fifo and shifts them out MSB-first
// on ds, one bit per enabled clock, with no gap between queued bytes.
// Optional macro SERIAL_PRBS_FILL_EN: drive ds from an LFSR while idle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | shifter empty; ds is fill (0 or LFSR MSB), waiting for a byte
//   SHIFT | shifter holds a byte; ds = sh[7], bitcnt counts bits sent
module serial_pattern_tx
  import serial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  input  logic              en,
  output logic              ds,
  output logic              ds_valid,
  output logic              busy,
  output logic [CNT_W-1:0]  fifo_cnt
);

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     sh_q, sh_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic [DATA_W-1:0]     fifo_rdata;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fill_bit;

  assign din_ready = !fifo_full;
  assign fifo_push = din_valid && din_ready;

  byte_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (din),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Shifter next-state: load from the FIFO head, shift, or chain into the next byte.
  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bitcnt_d = bitcnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !fifo_empty) begin
          fifo_pop = 1'b1;
          sh_d     = fifo_rdata;
          bitcnt_d = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          if (bitcnt_q != BIT_LAST) begin
            sh_d     = {sh_q[DATA_W-2:0], 1'b0};
            bitcnt_d = bitcnt_q + BITCNT_W'(1);
          end else if (!fifo_empty) begin
            // Reload on the last bit so consecutive bytes stream without a gap.
            fifo_pop = 1'b1;
            sh_d     = fifo_rdata;
            bitcnt_d = '0;
          end else begin
            sh_d     = '0;
            bitcnt_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Shifter state registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      bitcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      bitcnt_q <= bitcnt_d;
    end
  end

`ifdef SERIAL_PRBS_FILL_EN
  logic [DATA_W-1:0] lfsr_q, lfsr_d;

  // Idle fill LFSR: advances only on enabled IDLE cycles.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == IDLE && en) begin
      lfsr_d = {lfsr_q[DATA_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  // LFSR register, reseeded on reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign fill_bit = lfsr_q[DATA_W-1];
`else
  assign fill_bit = 1'b0;
`endif

  // en=0 freezes the shifter, so ds keeps its value but is not marked valid.
  assign busy     = (state_q == SHIFT);
  assign ds       = busy ? sh_q[DATA_W-1] : fill_bit;
  assign ds_valid = busy && en;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: stream-level reference model (expected bit
// queue built MSB-first from accepted bytes) compared against bits captured
// whenever ds_valid is high, plus targeted timing and boundary checks.
module tb_serial_pattern_tx;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             clrn;
  logic [7:0]       din;
  logic             din_valid;
  logic             din_ready;
  logic             en;
  logic             ds;
  logic             ds_valid;
  logic             busy;
  logic [CNT_W-1:0] fifo_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic       rx_q[$];
  int         rx_cyc[$];
  logic       exp_q[$];
  logic [7:0] pend[$];
  int         max_cnt;
  bit         saw_full;
  bit         ready_bad;
  int         stall_cnt;
  int         accept_cyc;

  serial_pattern_tx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .clrn      (clrn),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .en        (en),
    .ds        (ds),
    .ds_valid  (ds_valid),
    .busy      (busy),
    .fifo_cnt  (fifo_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Capture valid bits and occupancy observations away from the active edge.
  always @(negedge clk) begin
    if (clrn) begin
      if (ds_valid) begin
        rx_q.push_back(ds);
        rx_cyc.push_back(cyc);
      end
      if (int'(fifo_cnt) > max_cnt) max_cnt = int'(fifo_cnt);
      if (fifo_cnt == CNT_W'(DEPTH) && !din_ready) saw_full = 1'b1;
      if (din_ready !== (int'(fifo_cnt) < DEPTH)) ready_bad = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_stream();
    rx_q.delete();
    rx_cyc.delete();
    exp_q.delete();
    max_cnt   = 0;
    saw_full  = 1'b0;
    ready_bad = 1'b0;
    stall_cnt = 0;
  endtask

  task automatic apply_reset();
    din_valid = 1'b0;
    din       = 8'h00;
    en        = 1'b1;
    clrn      = 1'b0;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  // Present each pending byte until accepted; accepted bytes extend the model stream.
  task automatic push_all();
    int waitc;
    for (int i = 0; i < pend.size(); i++) begin
      din       = pend[i];
      din_valid = 1'b1;
      waitc     = 0;
      while (!din_ready && waitc < 200) begin
        tick();
        waitc++;
        stall_cnt++;
      end
      if (!din_ready) begin
        n_cmp++;
        n_err++;
        $display("FAIL push_timeout byte=%0d din_ready=%0b want 1", i, din_ready);
      end else begin
        accept_cyc = cyc + 1;
        for (int b = 7; b >= 0; b--) exp_q.push_back(pend[i][b]);
      end
      tick();
    end
    din_valid = 1'b0;
    pend.delete();
  endtask

  task automatic wait_drain();
    int k = 0;
    en = 1'b1;
    while ((busy || fifo_cnt != 0) && k < 500) begin
      tick();
      k++;
    end
    if (busy || fifo_cnt != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout busy=%0b cnt=%0d want 0/0", busy, fifo_cnt);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    din_valid = 1'b0;
    din       = 8'h00;
    en        = 1'b1;
    clrn      = 1'b0;
    #3;
    n_cmp++; if (ds !== 1'b0)        begin n_err++; $display("FAIL rst_ds got %0b want 0", ds); end
    n_cmp++; if (ds_valid !== 1'b0)  begin n_err++; $display("FAIL rst_ds_valid got %0b want 0", ds_valid); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL rst_busy got %0b want 0", busy); end
    n_cmp++; if (fifo_cnt !== '0)    begin n_err++; $display("FAIL rst_cnt got %0d want 0", fifo_cnt); end
    n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", din_ready); end
    tick();
    tick();
    clrn = 1'b1;
    tick();
    tick();
    n_cmp++; if (busy !== 1'b0 || fifo_cnt !== '0 || ds_valid !== 1'b0)
      begin n_err++; $display("FAIL rst_idle busy=%0b cnt=%0d dsv=%0b want 0/0/0", busy, fifo_cnt, ds_valid); end
  endtask

  task automatic test_single_byte();
    apply_reset();
    clear_stream();
    pend.push_back(8'hB5);
    push_all();
    wait_drain();
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_err++; $display("FAIL b5_len got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL b5_bit%0d got %0b want %0b", i, rx_q[i], exp_q[i]); end
      end
      n_cmp++; if (rx_cyc[0] != accept_cyc + 1) begin n_err++; $display("FAIL b5_first_cyc got %0d want %0d", rx_cyc[0], accept_cyc + 1); end
      n_cmp++; if (rx_cyc[7] != accept_cyc + 8) begin n_err++; $display("FAIL b5_last_cyc got %0d want %0d", rx_cyc[7], accept_cyc + 8); end
    end
    n_cmp++; if (busy !== 1'b0 || ds_valid !== 1'b0) begin n_err++; $display("FAIL b5_after busy=%0b dsv=%0b want 0/0", busy, ds_valid); end
`ifndef SERIAL_PRBS_FILL_EN
    n_cmp++; if (ds !== 1'b0) begin n_err++; $display("FAIL b5_idle_ds got %0b want 0", ds); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    pat = 16'hA53C;
    apply_reset();
    clear_stream();
    pend.push_back(8'hA5);
    pend.push_back(8'h3C);
    push_all();
    wait_drain();
    n_cmp++;
    if (rx_q.size() != 16) begin
      n_err++; $display("FAIL b2b_len got %0d want 16", rx_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        n_cmp++;
        if (rx_q[i] !== pat[15-i]) begin n_err++; $display("FAIL b2b_bit%0d got %0b want %0b", i, rx_q[i], pat[15-i]); end
      end
      n_cmp++; if (rx_cyc[15] - rx_cyc[0] != 15) begin n_err++; $display("FAIL b2b_gap span got %0d want 15", rx_cyc[15] - rx_cyc[0]); end
    end
    n_cmp++; if (max_cnt != 1) begin n_err++; $display("FAIL b2b_peak got %0d want 1", max_cnt); end
  endtask

  task automatic test_fifo_full();
    apply_reset();
    clear_stream();
    for (int i = 0; i < 6; i++) pend.push_back(8'($urandom_range(0, 255)));
    push_all();
    wait_drain();
    n_cmp++; if (max_cnt != DEPTH) begin n_err++; $display("FAIL full_peak got %0d want %0d", max_cnt, DEPTH); end
    n_cmp++; if (!saw_full)        begin n_err++; $display("FAIL full_notready got 0 want 1"); end
    n_cmp++; if (ready_bad)        begin n_err++; $display("FAIL ready_rule got 1 want 0"); end
    n_cmp++; if (stall_cnt == 0)   begin n_err++; $display("FAIL full_stall got %0d want >0", stall_cnt); end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL full_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL full_bit%0d got %0b want %0b", i, rx_q[i], exp_q[i]); end
      end
      n_cmp++; if (rx_cyc[47] - rx_cyc[0] != 47) begin n_err++; $display("FAIL full_gap span got %0d want 47", rx_cyc[47] - rx_cyc[0]); end
    end
  endtask

  task automatic test_en_pause();
    int k = 0;
    apply_reset();
    clear_stream();
    pend.push_back(8'hF0);
    push_all();
    while (rx_q.size() < 4 && k < 50) begin tick(); k++; end
    n_cmp++;
    if (rx_q.size() < 4) begin
      n_err++; $display("FAIL pause_wait got %0d bits want 4", rx_q.size());
    end else begin
      @(posedge clk); #1;
      en = 1'b0;
      for (int h = 0; h < 3; h++) begin
        @(negedge clk); #1;
        n_cmp++;
        if (ds !== 1'b0 || ds_valid !== 1'b0 || busy !== 1'b1)
          begin n_err++; $display("FAIL pause_hold%0d ds=%0b dsv=%0b busy=%0b want 0/0/1", h, ds, ds_valid, busy); end
      end
      @(posedge clk); #1;
      en = 1'b1;
    end
    wait_drain();
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_err++; $display("FAIL pause_len got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL pause_bit%0d got %0b want %0b", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_async_reset();
    int k = 0;
    int n_seen;
    apply_reset();
    clear_stream();
    for (int i = 0; i < 3; i++) pend.push_back(8'($urandom_range(0, 255)));
    push_all();
    while (rx_q.size() < 3 && k < 50) begin tick(); k++; end
    #2;
    clrn = 1'b0;
    #1;
    n_cmp++; if (ds !== 1'b0)        begin n_err++; $display("FAIL arst_ds got %0b want 0", ds); end
    n_cmp++; if (fifo_cnt !== '0)    begin n_err++; $display("FAIL arst_cnt got %0d want 0", fifo_cnt); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL arst_busy got %0b want 0", busy); end
    n_cmp++; if (ds_valid !== 1'b0)  begin n_err++; $display("FAIL arst_dsv got %0b want 0", ds_valid); end
    n_cmp++; if (din_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready got %0b want 1", din_ready); end
    n_seen = rx_q.size();
    tick();
    tick();
    clrn = 1'b1;
    en   = 1'b1;
    repeat (20) tick();
    n_cmp++; if (rx_q.size() != n_seen) begin n_err++; $display("FAIL arst_residual got %0d extra bits want 0", rx_q.size() - n_seen); end
    n_cmp++; if (busy !== 1'b0 || fifo_cnt !== '0) begin n_err++; $display("FAIL arst_after busy=%0b cnt=%0d want 0/0", busy, fifo_cnt); end
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    int  idx = 0;
    int  k   = 0;
    bit  acc;
    apply_reset();
    clear_stream();
    for (int i = 0; i < 40; i++) bytes.push_back(8'($urandom_range(0, 255)));
    din_valid = 1'b0;
    while (idx < 40 && k < 4000) begin
      n_cmp++;
      if (ds_valid && !en) begin n_err++; $display("FAIL rnd_dsv_en got dsv=1 en=0 want dsv=0"); end
      en  = ($urandom_range(0, 4) != 0);
      acc = 1'b0;
      if (!din_valid) din_valid = ($urandom_range(0, 2) != 0);
      if (din_valid) begin
        din = bytes[idx];
        if (din_ready) begin
          for (int b = 7; b >= 0; b--) exp_q.push_back(bytes[idx][b]);
          idx++;
          acc = 1'b1;
        end
      end
      tick();
      k++;
      if (acc) din_valid = ($urandom_range(0, 2) != 0);
    end
    din_valid = 1'b0;
    if (idx < 40) begin
      n_cmp++; n_err++;
      $display("FAIL rnd_timeout accepted %0d want 40", idx);
    end
    wait_drain();
    n_cmp++; if (ready_bad) begin n_err++; $display("FAIL rnd_ready_rule got 1 want 0"); end
    n_cmp++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rnd_len got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rnd_bit%0d got %0b want %0b", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

`ifdef SERIAL_PRBS_FILL_EN
  task automatic test_prbs_fill();
    logic [7:0] m;
    logic       fb;
    apply_reset();
    clear_stream();
    m = 8'h01;
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (ds !== m[7] || ds_valid !== 1'b0)
        begin n_err++; $display("FAIL prbs_cyc%0d ds=%0b dsv=%0b want %0b/0", i, ds, ds_valid, m[7]); end
      fb = m[7] ^ m[5] ^ m[4] ^ m[3];
      m  = {m[6:0], fb};
      tick();
    end
    pend.push_back(8'($urandom_range(0, 255)));
    push_all();
    wait_drain();
    n_cmp++;
    if (rx_q.size() != 8) begin
      n_err++; $display("FAIL prbs_len got %0d want 8", rx_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_err++; $display("FAIL prbs_bit%0d got %0b want %0b", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask
`endif

  initial begin
    clrn      = 1'b0;
    din_valid = 1'b0;
    din       = 8'h00;
    en        = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_fifo_full();
    test_en_pause();
    test_async_reset();
    test_random();
`ifdef SERIAL_PRBS_FILL_EN
    test_prbs_fill();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
